// File: rtl/program_loader.sv
// Boot-time program loader: takes a length-prefixed little-endian byte stream,
// assembles 32-bit instruction words, writes them sequentially into instruction
// memory, and holds the CPU in reset until the whole image has been written.
module program_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal image length: exactly fills memory.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   word_idx;     // one extra bit so a full-memory image is representable
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;        // low three bytes of the word being assembled
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              xfer;
    logic [15:0]       len_full;
    logic [16:0]       word_count;
    logic              last_word;

    assign xfer       = byte_valid && byte_ready;
    assign len_full   = {byte_data, len_q[7:0]};
    assign word_count = 17'(word_idx) + 17'd1;
    assign last_word  = (word_count == {1'b0, len_q});

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block evaluation order.
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN0;
            S_LEN0:  if (xfer) state_next = S_LEN1;
            S_LEN1: begin
                if (xfer) begin
                    if (len_full == 16'd0)                     state_next = S_DONE;
                    else if ({1'b0, len_full} > CAPACITY)      state_next = S_ERR;
                    else                                       state_next = S_DATA;
                end
            end
            S_DATA:  if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
            S_WRITE: state_next = last_word ? S_DONE : S_DATA;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            S_LEN0, S_LEN1, S_DATA: byte_ready = 1'b1;
            S_WRITE:                mem_we     = 1'b1;
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:                  err        = 1'b1;
            default: ;
        endcase
    end

    // Length capture, byte assembly, and word/byte index bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            unique case (state)
                S_LEN0: if (xfer) len_q[7:0] <= byte_data;
                S_LEN1: begin
                    if (xfer) begin
                        len_q[15:8] <= byte_data;
                        word_idx    <= '0;
                        byte_idx    <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: asm_q[7:0]   <= byte_data;
                            2'd1: asm_q[15:8]  <= byte_data;
                            2'd2: asm_q[23:16] <= byte_data;
                            default: begin
                                // Final byte: publish the whole word and its address
                                // together so both hold steady until the next write.
                                wdata_q <= {byte_data, asm_q};
                                addr_q  <= word_idx[ADDR_W-1:0];
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
